// File: rtl/pulse_train_sequencer_if.sv
// Control/status bundle between the start/abort source and the pulse-train sequencer.
interface pulse_train_sequencer_if #(
    parameter int NUM_WR = 3,
    parameter int DAC_W  = 8
);
    localparam int SLOT_W = $clog2(NUM_WR + 1);

    logic              start;
    logic              abort;
    logic [NUM_WR-1:0] pattern;
    logic [DAC_W-1:0]  dac_code;
    logic              busy;
    logic              done;
    logic [SLOT_W-1:0] slot_idx;
    logic              sample_stb;

    modport master (
        output start, abort, pattern,
        input  dac_code, busy, done, slot_idx, sample_stb
    );

    modport slave (
        input  start, abort, pattern,
        output dac_code, busy, done, slot_idx, sample_stb
    );
endinterface

// File: rtl/pulse_train_sequencer.sv
// Read/write pulse-train generator driving an offset-binary DAC code.
// Optional read-sample strobe enabled by defining PTS_SAMPLE_STROBE_EN.
//
// state   | meaning
// IDLE    | DAC at zero, waiting for start
// READ    | read pulse at READ_CODE
// GAP     | zero-level gap; gap_after_write tells which pulse it follows
// WRITE   | write pulse, code chosen by latched pattern bit of slot_idx
// DONE    | single-cycle completion strobe
module pulse_train_sequencer #(
    parameter int DAC_W     = 8,
    parameter int NUM_WR    = 3,
    parameter int CNT_W     = 24,
    parameter int READ_LEN  = 100000,
    parameter int WRITE_LEN = 100000,
    parameter int GAP_LEN   = 50000,
    parameter int ZERO_CODE = 128,
    parameter int READ_CODE = 153,
    parameter int WR1_CODE  = 191,
    parameter int WR0_CODE  = 128
) (
    input logic clk,
    input logic reset,
    pulse_train_sequencer_if.slave bus
);
    localparam int SLOT_W = $clog2(NUM_WR + 1);

    localparam logic [CNT_W-1:0]  READ_LAST  = CNT_W'(READ_LEN - 1);
    localparam logic [CNT_W-1:0]  WRITE_LAST = CNT_W'(WRITE_LEN - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_LEN - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_WR);
    localparam logic [DAC_W-1:0]  C_ZERO     = DAC_W'(ZERO_CODE);
    localparam logic [DAC_W-1:0]  C_READ     = DAC_W'(READ_CODE);
    localparam logic [DAC_W-1:0]  C_WR1      = DAC_W'(WR1_CODE);
    localparam logic [DAC_W-1:0]  C_WR0      = DAC_W'(WR0_CODE);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_GAP, S_WRITE, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_WR-1:0] pattern_l;
    logic              gap_after_write;
    logic [DAC_W-1:0]  dac_q;
    logic              busy_q;
    logic              done_q;
    logic [SLOT_W-1:0] slot_q;
    logic              stb_q;
    logic              wr_bit;

    assign wr_bit = |(pattern_l & (NUM_WR'(1) << slot_q));

`ifdef PTS_SAMPLE_STROBE_EN
    localparam logic [CNT_W-1:0] READ_HALF = CNT_W'(READ_LEN / 2);
    localparam logic             HALF_AT_ENTRY = (READ_LEN / 2 == 0);
`else
    localparam logic [CNT_W-1:0] READ_HALF = '0;
    localparam logic             HALF_AT_ENTRY = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            pattern_l       <= '0;
            gap_after_write <= 1'b0;
            dac_q           <= C_ZERO;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            slot_q          <= '0;
            stb_q           <= 1'b0;
        end else begin
            done_q <= 1'b0;
            stb_q  <= 1'b0;
            if (state != S_IDLE && bus.abort) begin
                state  <= S_IDLE;
                cnt    <= '0;
                dac_q  <= C_ZERO;
                busy_q <= 1'b0;
                slot_q <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // abort outranks a coincident start
                        if (bus.start && !bus.abort) begin
                            pattern_l <= bus.pattern;
                            state     <= S_READ;
                            cnt       <= '0;
                            slot_q    <= '0;
                            busy_q    <= 1'b1;
                            dac_q     <= C_READ;
                            stb_q     <= HALF_AT_ENTRY;
                        end
                    end
                    S_READ: begin
                        if (cnt == READ_LAST) begin
                            state           <= S_GAP;
                            gap_after_write <= 1'b0;
                            cnt             <= '0;
                            dac_q           <= C_ZERO;
                        end else begin
                            cnt <= cnt + 1'b1;
`ifdef PTS_SAMPLE_STROBE_EN
                            stb_q <= (cnt + 1'b1 == READ_HALF);
`endif
                        end
                    end
                    S_GAP: begin
                        if (cnt == GAP_LAST) begin
                            cnt <= '0;
                            if (gap_after_write) begin
                                state  <= S_READ;
                                slot_q <= slot_q + 1'b1;
                                dac_q  <= C_READ;
                                stb_q  <= HALF_AT_ENTRY;
                            end else if (slot_q < SLOT_LAST) begin
                                state <= S_WRITE;
                                dac_q <= wr_bit ? C_WR1 : C_WR0;
                            end else begin
                                state  <= S_DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                dac_q  <= C_ZERO;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_WRITE: begin
                        if (cnt == WRITE_LAST) begin
                            state           <= S_GAP;
                            gap_after_write <= 1'b1;
                            cnt             <= '0;
                            dac_q           <= C_ZERO;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        cnt    <= '0;
                        slot_q <= '0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        cnt    <= '0;
                        dac_q  <= C_ZERO;
                        busy_q <= 1'b0;
                        slot_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.dac_code = dac_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.slot_idx = slot_q;
`ifdef PTS_SAMPLE_STROBE_EN
    assign bus.sample_stb = stb_q;
`else
    assign bus.sample_stb = 1'b0;
`endif
endmodule

// File: tb/tb_pulse_train_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a negedge monitor compares them.
module tb_pulse_train_sequencer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pulse_train_sequencer_if #(.NUM_WR(3), .DAC_W(8)) bus ();

    pulse_train_sequencer #(
        .DAC_W(8), .NUM_WR(3), .CNT_W(8),
        .READ_LEN(4), .WRITE_LEN(4), .GAP_LEN(2),
        .ZERO_CODE(128), .READ_CODE(153), .WR1_CODE(191), .WR0_CODE(128)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] dac;
        logic       busy;
        logic       done;
        logic       stb;
        logic [1:0] slot;
        bit         chk_slot;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

`ifdef PTS_SAMPLE_STROBE_EN
    localparam bit STB_ON = 1'b1;
`else
    localparam bit STB_ON = 1'b0;
`endif

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            step++;
            if (bus.dac_code !== e.dac || bus.busy !== e.busy || bus.done !== e.done ||
                bus.sample_stb !== e.stb || (e.chk_slot && bus.slot_idx !== e.slot)) begin
                errors++;
                $display("FAIL step%0d: got dac=%0d busy=%b done=%b stb=%b slot=%0d, expected dac=%0d busy=%b done=%b stb=%b slot=%0d",
                         step, bus.dac_code, bus.busy, bus.done, bus.sample_stb, bus.slot_idx,
                         e.dac, e.busy, e.done, e.stb, e.slot);
            end
        end
    end

    function automatic exp_t mk(logic [7:0] dac, logic busy, logic done, logic stb,
                                logic [1:0] slot, bit chk);
        exp_t e;
        e.dac = dac; e.busy = busy; e.done = done; e.stb = stb; e.slot = slot; e.chk_slot = chk;
        return e;
    endfunction

    task automatic push_idle(int n);
        for (int i = 0; i < n; i++) q.push_back(mk(8'd128, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));
    endtask

    // Entry 0 is cycle t (start not yet captured); entries 1..42 busy; entry 43 done.
    task automatic push_seq(logic [2:0] pat, int abort_at);
        exp_t tmp[$];
        tmp.push_back(mk(8'd128, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++)
                tmp.push_back(mk(8'd153, 1'b1, 1'b0, STB_ON && (i == 2), 2'(k), 1'b1));
            for (int i = 0; i < 2; i++)
                tmp.push_back(mk(8'd128, 1'b1, 1'b0, 1'b0, 2'(k), 1'b1));
            if (k < 3) begin
                for (int i = 0; i < 4; i++)
                    tmp.push_back(mk(pat[k] ? 8'd191 : 8'd128, 1'b1, 1'b0, 1'b0, 2'(k), 1'b1));
                for (int i = 0; i < 2; i++)
                    tmp.push_back(mk(8'd128, 1'b1, 1'b0, 1'b0, 2'(k), 1'b1));
            end
        end
        tmp.push_back(mk(8'd128, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0));
        for (int i = 0; i < tmp.size(); i++) begin
            if (abort_at > 0 && i == abort_at + 1) begin
                push_idle(5);
                return;
            end
            q.push_back(tmp[i]);
        end
        push_idle(3);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d entries left, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.pattern = 3'b000;

        // Reset values while reset is held, then 10 idle cycles.
        tick();
        push_idle(2);
        wait_drain();
        reset = 1'b0;
        push_idle(10);
        wait_drain();

        // Full sequence, pattern 101.
        bus.pattern = 3'b101;
        bus.start = 1'b1;
        push_seq(3'b101, 0);
        tick();
        bus.start = 1'b0;
        wait_drain();

        // Extra start at t+10 is ignored.
        bus.start = 1'b1;
        push_seq(3'b101, 0);
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_drain();

        // Abort at t+15, then a full sequence.
        bus.start = 1'b1;
        push_seq(3'b101, 15);
        tick();
        bus.start = 1'b0;
        repeat (14) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        wait_drain();
        bus.start = 1'b1;
        push_seq(3'b101, 0);
        tick();
        bus.start = 1'b0;
        wait_drain();

        // Pattern change mid-sequence has no effect.
        bus.start = 1'b1;
        push_seq(3'b101, 0);
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.pattern = 3'b010;
        wait_drain();

        // Pattern 010 run, then start+abort together in IDLE.
        bus.start = 1'b1;
        push_seq(3'b010, 0);
        tick();
        bus.start = 1'b0;
        wait_drain();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        push_idle(6);
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        wait_drain();

        // Reset mid-sequence returns to idle with no done.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        #1;
        push_idle(2);
        wait_drain();
        reset = 1'b0;
        push_idle(4);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
